vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Two-port arbiter (A = CPU, B = video line fetch) onto one single-port memory.
// Define VRAM_ARBITER_STATS_EN to add per-port grant counters o_stat_a_grants/o_stat_b_grants.
module vram_arbiter #(
    parameter int unsigned MAX_B_BURST = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pa_request,
    input  logic        i_pa_rw,
    input  logic [31:0] i_pa_address,
    input  logic [31:0] i_pa_wdata,
    output logic [31:0] o_pa_rdata,
    output logic        o_pa_ready,
    input  logic        i_pb_request,
    input  logic        i_pb_rw,
    input  logic [31:0] i_pb_address,
    input  logic [31:0] i_pb_wdata,
    output logic [31:0] o_pb_rdata,
    output logic        o_pb_ready,
    output logic        o_mem_request,
    output logic        o_mem_rw,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready
`ifdef VRAM_ARBITER_STATS_EN
    ,
    output logic [31:0] o_stat_a_grants,
    output logic [31:0] o_stat_b_grants
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_A = 2'd1;
    localparam logic [1:0] BUSY_B = 2'd2;

    localparam int unsigned CW = (MAX_B_BURST > 0) ? $clog2(MAX_B_BURST + 1) : 1;

    logic [1:0]    state;
    logic [CW-1:0] b_burst;
    logic          burst_full;
    logic          grant_a;
    logic          grant_b;

    assign burst_full = (b_burst == CW'(MAX_B_BURST));

    // B wins ties until it has starved a pending A for MAX_B_BURST grants.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (i_pb_request && !(i_pa_request && burst_full)) begin
                grant_b = 1'b1;
            end else if (i_pa_request) begin
                grant_a = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            b_burst       <= '0;
            o_mem_request <= 1'b0;
            o_mem_rw      <= 1'b0;
            o_mem_address <= '0;
            o_mem_wdata   <= '0;
            o_pa_rdata    <= '0;
            o_pb_rdata    <= '0;
            o_pa_ready    <= 1'b0;
            o_pb_ready    <= 1'b0;
        end else begin
            o_pa_ready <= 1'b0;
            o_pb_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a) begin
                        o_mem_request <= 1'b1;
                        o_mem_rw      <= i_pa_rw;
                        o_mem_address <= i_pa_address;
                        o_mem_wdata   <= i_pa_wdata;
                        state         <= BUSY_A;
                    end else if (grant_b) begin
                        o_mem_request <= 1'b1;
                        o_mem_rw      <= i_pb_rw;
                        o_mem_address <= i_pb_address;
                        o_mem_wdata   <= i_pb_wdata;
                        state         <= BUSY_B;
                    end
                end
                BUSY_A: begin
                    if (i_mem_ready) begin
                        o_mem_request <= 1'b0;
                        o_pa_rdata    <= i_mem_rdata;
                        o_pa_ready    <= 1'b1;
                        state         <= IDLE;
                    end
                end
                BUSY_B: begin
                    if (i_mem_ready) begin
                        o_mem_request <= 1'b0;
                        o_pb_rdata    <= i_mem_rdata;
                        o_pb_ready    <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    o_mem_request <= 1'b0;
                    state         <= IDLE;
                end
            endcase

            if (!i_pa_request || grant_a) begin
                b_burst <= '0;
            end else if (grant_b && !burst_full) begin
                b_burst <= b_burst + 1'b1;
            end
        end
    end

`ifdef VRAM_ARBITER_STATS_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_stat_a_grants <= '0;
            o_stat_b_grants <= '0;
        end else begin
            if (grant_a) o_stat_a_grants <= o_stat_a_grants + 32'd1;
            if (grant_b) o_stat_b_grants <= o_stat_b_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: random port masters, a memory responder and a
// priority model predicting each grant; stats checks apply when VRAM_ARBITER_STATS_EN is defined.
module tb_vram_arbiter;

    localparam int MAXB = 16;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pa_req, pa_rw, pa_ready, pb_req, pb_rw, pb_ready;
    logic [31:0] pa_addr, pa_wdata, pa_rdata, pb_addr, pb_wdata, pb_rdata;
    logic        mem_req, mem_rw, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef VRAM_ARBITER_STATS_EN
    logic [31:0] stat_a, stat_b;
`endif

    always #5 clk = ~clk;

    vram_arbiter #(.MAX_B_BURST(MAXB)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_pa_request(pa_req), .i_pa_rw(pa_rw), .i_pa_address(pa_addr), .i_pa_wdata(pa_wdata),
        .o_pa_rdata(pa_rdata), .o_pa_ready(pa_ready),
        .i_pb_request(pb_req), .i_pb_rw(pb_rw), .i_pb_address(pb_addr), .i_pb_wdata(pb_wdata),
        .o_pb_rdata(pb_rdata), .o_pb_ready(pb_ready),
        .o_mem_request(mem_req), .o_mem_rw(mem_rw), .o_mem_address(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
`ifdef VRAM_ARBITER_STATS_EN
        , .o_stat_a_grants(stat_a), .o_stat_b_grants(stat_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // ---------------- shared scoreboard state ----------------
    txn_t        a_stim[$], b_stim[$];
    txn_t        exp_a[$], exp_b[$];
    int          grant_q[$], grant_log[$], low_log[$];
    logic [31:0] ret_q[$];
    logic [31:0] mem [logic [31:0]];
    int          done_a = 0, done_b = 0;
    int          mem_delay = -1;
    bit          mem_hold = 1'b0;
    int          spur_cnt = 0;

    // ---------------- port A master ----------------
    txn_t a_next;
    bit   a_has_next, a_busy;
    int   a_wait;
    initial begin
        pa_req = 1'b0; pa_rw = 1'b0; pa_addr = '0; pa_wdata = '0;
        a_has_next = 1'b0; a_busy = 1'b0; a_wait = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                pa_req = 1'b0; a_busy = 1'b0; a_has_next = 1'b0; a_stim.delete();
            end else begin
                if (a_busy && pa_ready) a_busy = 1'b0;
                if (!a_busy) begin
                    if (!a_has_next && a_stim.size() > 0) begin
                        a_next = a_stim.pop_front(); a_wait = a_next.gap; a_has_next = 1'b1;
                    end
                    if (a_has_next && a_wait == 0) begin
                        pa_req = 1'b1; pa_rw = a_next.rw; pa_addr = a_next.addr; pa_wdata = a_next.wdata;
                        exp_a.push_back(a_next); a_busy = 1'b1; a_has_next = 1'b0;
                    end else begin
                        pa_req = 1'b0;
                        if (a_has_next) a_wait--;
                    end
                end
            end
        end
    end

    // ---------------- port B master ----------------
    txn_t b_next;
    bit   b_has_next, b_busy;
    int   b_wait;
    initial begin
        pb_req = 1'b0; pb_rw = 1'b0; pb_addr = '0; pb_wdata = '0;
        b_has_next = 1'b0; b_busy = 1'b0; b_wait = 0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                pb_req = 1'b0; b_busy = 1'b0; b_has_next = 1'b0; b_stim.delete();
            end else begin
                if (b_busy && pb_ready) b_busy = 1'b0;
                if (!b_busy) begin
                    if (!b_has_next && b_stim.size() > 0) begin
                        b_next = b_stim.pop_front(); b_wait = b_next.gap; b_has_next = 1'b1;
                    end
                    if (b_has_next && b_wait == 0) begin
                        pb_req = 1'b1; pb_rw = b_next.rw; pb_addr = b_next.addr; pb_wdata = b_next.wdata;
                        exp_b.push_back(b_next); b_busy = 1'b1; b_has_next = 1'b0;
                    end else begin
                        pb_req = 1'b0;
                        if (b_has_next) b_wait--;
                    end
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    bit          m_busy;
    int          m_cnt, spur_seen;
    logic        m_rw;
    logic [31:0] m_addr;
    initial begin
        mem_ready = 1'b0; mem_rdata = '0; m_busy = 1'b0; m_cnt = 0; spur_seen = 0;
        m_rw = 1'b0; m_addr = '0;
        forever begin
            @(negedge clk); #2;
            mem_ready = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else if (spur_seen != spur_cnt) begin
                spur_seen++; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
            end else begin
                if (!m_busy && mem_req && !mem_hold) begin
                    m_busy = 1'b1; m_rw = mem_rw; m_addr = mem_addr;
                    m_cnt = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
                end
                if (m_busy) begin
                    if (m_cnt == 0) begin
                        if (m_rw) begin
                            mem[m_addr] = mem_wdata; mem_rdata = $urandom;
                        end else begin
                            mem_rdata = mem.exists(m_addr) ? mem[m_addr] : (m_addr ^ 32'h5A5A_0000);
                        end
                        mem_ready = 1'b1; ret_q.push_back(mem_rdata); m_busy = 1'b0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- monitor / reference arbitration model ----------------
    logic        prev_mreq = 1'b0, prev_ra = 1'b0, prev_rb = 1'b0;
    int          b_run = 0, low_run = 0, mon_p, mon_g;
    logic [64:0] cur_f;
    txn_t        mon_t;
    logic [31:0] mon_r;
    always @(negedge clk) begin
        if (rst) begin
            grant_q.delete(); exp_a.delete(); exp_b.delete(); ret_q.delete();
            b_run = 0; low_run = 0; prev_mreq = 1'b0; prev_ra = 1'b0; prev_rb = 1'b0;
        end else begin
            if (mem_req && !prev_mreq) begin
                // Winner from the rules: B on ties unless B already took MAXB grants while A waited.
                if (pa_req && pb_req) mon_p = (b_run >= MAXB) ? 0 : 1;
                else mon_p = pa_req ? 0 : 1;
                check(pa_req || pb_req, "grant_without_request", 160'(mem_addr), 160'd0);
                if ((mon_p == 0 && exp_a.size() == 0) || (mon_p == 1 && exp_b.size() == 0)) begin
                    check(1'b0, "grant_port", 160'(1 - mon_p), 160'(mon_p));
                end else begin
                    mon_t = (mon_p == 0) ? exp_a[0] : exp_b[0];
                    check({mem_rw, mem_addr, mem_wdata} == {mon_t.rw, mon_t.addr, mon_t.wdata},
                          "grant_fields", 160'({mem_rw, mem_addr, mem_wdata}),
                          160'({mon_t.rw, mon_t.addr, mon_t.wdata}));
                end
                grant_q.push_back(mon_p); grant_log.push_back(mon_p); low_log.push_back(low_run);
                if (mon_p == 0) b_run = 0;
                else if (pa_req) b_run++;
                cur_f = {mem_rw, mem_addr, mem_wdata};
            end else if (mem_req) begin
                check({mem_rw, mem_addr, mem_wdata} == cur_f, "mem_stable",
                      160'({mem_rw, mem_addr, mem_wdata}), 160'(cur_f));
            end
            low_run = mem_req ? 0 : low_run + 1;

            if (pa_ready || pb_ready) begin
                mon_p = pb_ready ? 1 : 0;
                check(!(pa_ready && pb_ready), "ready_exclusive", 160'({pa_ready, pb_ready}), 160'd0);
                check(!((mon_p == 0) ? prev_ra : prev_rb), "ready_single_cycle", 160'd1, 160'd0);
                if (grant_q.size() == 0) begin
                    check(1'b0, "ready_unexpected", 160'(mon_p), 160'd0);
                end else begin
                    mon_g = grant_q.pop_front();
                    check(mon_g == mon_p, "ready_port", 160'(mon_p), 160'(mon_g));
                    if (mon_p == 0 && exp_a.size() > 0) mon_t = exp_a.pop_front();
                    else if (mon_p == 1 && exp_b.size() > 0) mon_t = exp_b.pop_front();
                    mon_r = (ret_q.size() > 0) ? ret_q.pop_front() : 32'hXXXX_XXXX;
                    if (!mon_t.rw)
                        check(((mon_p == 0) ? pa_rdata : pb_rdata) === mon_r, "rdata",
                              160'((mon_p == 0) ? pa_rdata : pb_rdata), 160'(mon_r));
                end
                if (mon_p == 0) done_a++; else done_b++;
            end
            prev_ra = pa_ready; prev_rb = pb_ready; prev_mreq = mem_req;
        end
    end

    // ---------------- directed + random sequences ----------------
    task automatic wait_done(input int na, input int nb, input string name);
        int n = 0;
        while ((done_a < na || done_b < nb) && n < 20000) begin
            @(negedge clk); n++;
        end
        @(negedge clk); #4;
        check(done_a >= na && done_b >= nb, name, 160'({32'(done_a), 32'(done_b)}),
              160'({32'(na), 32'(nb)}));
    endtask

    task automatic push_txn(input int port, input logic rw, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gap);
        txn_t t;
        t.rw = rw; t.addr = addr; t.wdata = wdata; t.gap = gap;
        if (port == 0) a_stim.push_back(t); else b_stim.push_back(t);
    endtask

    function automatic logic [159:0] out_vec();
        return {28'd0, mem_req, mem_rw, pa_ready, pb_ready, mem_addr, mem_wdata, pa_rdata, pb_rdata};
    endfunction

    initial begin
        int da, db, idx, k, n;
        repeat (3) @(negedge clk);
        #4;
        check(out_vec() == '0, "reset_outputs", out_vec(), 160'd0);
        rst = 1'b0;
`ifdef VRAM_ARBITER_STATS_EN
        check({stat_a, stat_b} == '0, "stats_reset", 160'({stat_a, stat_b}), 160'd0);
`endif

        // single A read, memory answers after 3 cycles
        mem[32'h100] = 32'hDEAD_BEEF; mem_delay = 3; da = done_a;
        push_txn(0, 1'b0, 32'h100, 32'h0, 0);
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        check(mem_req, "mem_request_seen", 160'(mem_req), 160'd1);
        check({mem_rw, mem_addr} == {1'b0, 32'h100}, "a_read_addr", 160'({mem_rw, mem_addr}), 160'h100);
        wait_done(da + 1, 0, "a_read_done");
        check(pa_rdata == 32'hDEAD_BEEF, "a_read_data", 160'(pa_rdata), 160'hDEAD_BEEF);

        // simultaneous A write / B read: B first, then A after one idle cycle
        mem_delay = -1; da = done_a; db = done_b; idx = grant_log.size();
        push_txn(0, 1'b1, 32'h10, 32'h55, 0);
        push_txn(1, 1'b0, 32'h2000, 32'h0, 0);
        wait_done(da + 1, db + 1, "tie_done");
        check(grant_log.size() >= idx + 2 && grant_log[idx] == 1 && grant_log[idx + 1] == 0,
              "tie_order_b_then_a", 160'(grant_log.size() >= idx + 2 ? {grant_log[idx], grant_log[idx + 1]} : 64'd0),
              160'({32'd1, 32'd0}));
        check(grant_log.size() >= idx + 2 && low_log[idx + 1] == 1, "tie_idle_gap",
              160'(grant_log.size() >= idx + 2 ? low_log[idx + 1] : -1), 160'd1);
        push_txn(0, 1'b0, 32'h10, 32'h0, 0);
        wait_done(da + 2, db + 1, "a_readback_done");
        check(pa_rdata == 32'h55, "a_readback_data", 160'(pa_rdata), 160'h55);

        // 40 back-to-back B reads with A pending: A wins after exactly MAXB B grants
        da = done_a; db = done_b; idx = grant_log.size();
        push_txn(0, 1'b0, 32'h500, 32'h0, 0);
        for (int i = 0; i < 40; i++) push_txn(1, 1'b0, 32'h3000 + 32'(4 * i), $urandom, 0);
        wait_done(da + 1, db + 40, "burst_done");
        k = idx;
        while (k < grant_log.size() && grant_log[k] != 0) k++;
        check(k - idx == MAXB, "burst_b_grants_before_a", 160'(k - idx), 160'(MAXB));

        // random mixed traffic
        da = done_a; db = done_b;
        for (int i = 0; i < 60; i++)
            push_txn(0, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                     $urandom, int'($urandom_range(0, 6)));
        for (int i = 0; i < 90; i++)
            push_txn(1, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                     $urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        wait_done(da + 60, db + 90, "random_done");

        // reset while BUSY_A, then a late memory ready
        mem_hold = 1'b1; da = done_a;
        push_txn(0, 1'b0, 32'h400, 32'h0, 0);
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        #4;
        check(mem_req && mem_addr == 32'h400, "busy_before_reset", 160'({mem_req, mem_addr}),
              160'({1'b1, 32'h400}));
        rst = 1'b1;
        #1;
        check(out_vec() == '0, "reset_async_outputs", out_vec(), 160'd0);
        repeat (2) @(negedge clk);
        #4;
        rst = 1'b0; mem_hold = 1'b0; spur_cnt++;
        repeat (6) @(negedge clk);
        #4;
        check(done_a == da, "no_ready_after_reset", 160'(done_a), 160'(da));
        check(out_vec() == '0, "idle_after_reset", out_vec(), 160'd0);
`ifdef VRAM_ARBITER_STATS_EN
        check({stat_a, stat_b} == '0, "stats_after_reset", 160'({stat_a, stat_b}), 160'd0);
`endif

        // 3 A grants and 5 B grants after reset
        da = done_a; db = done_b;
        for (int i = 0; i < 3; i++) push_txn(0, 1'b0, 32'h600 + 32'(4 * i), $urandom, int'($urandom_range(0, 3)));
        for (int i = 0; i < 5; i++) push_txn(1, 1'b1, 32'h700 + 32'(4 * i), $urandom, int'($urandom_range(0, 2)));
        wait_done(da + 3, db + 5, "stats_traffic_done");
`ifdef VRAM_ARBITER_STATS_EN
        check(stat_a == 32'd3, "stat_a_grants", 160'(stat_a), 160'd3);
        check(stat_b == 32'd5, "stat_b_grants", 160'(stat_b), 160'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
